// File: rtl/fb_pkg.sv
// Shared types for the framebuffer swap controller.
// Holds the FSM state encoding, counter widths and a saturating-increment helper.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_DRAW    = 2'd2,
        ST_WAIT_VB = 2'd3
    } fb_state_t;

    localparam int MISS_W  = 16;
    localparam int SINCE_W = 8;

    function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + MISS_W'(1);
    endfunction

    function automatic logic [SINCE_W-1:0] since_sat_inc(input logic [SINCE_W-1:0] v);
        return (&v) ? v : v + SINCE_W'(1);
    endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller: sequences clear/draw passes on the back buffer and
// flips front/back only on a vblank once enough frames have elapsed; counts missed vblanks.
module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter int MIN_FRAMES = 1,
    parameter bit CLEAR_EN   = 1'b1
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              vblank_start,
    input  logic              draw_done,
    input  logic              clear_done,
    output logic              front_sel,
    output logic              back_sel,
    output logic              clear_start,
    output logic              draw_start,
    output logic              swap_pulse,
    output logic [1:0]        state,
    output logic [MISS_W-1:0] miss_cnt
);

    // Every new back-buffer job opens with a clear pass unless clearing is disabled.
    localparam fb_state_t JOB_ST = CLEAR_EN ? ST_CLEAR : ST_DRAW;

    fb_state_t            state_q;
    logic                 front_q;
    logic                 clear_start_q;
    logic                 draw_start_q;
    logic                 swap_pulse_q;
    logic [SINCE_W-1:0]   since_q;
    logic [SINCE_W-1:0]   since_d;
    logic [MISS_W-1:0]    miss_cnt_q;
    logic [MISS_W-1:0]    miss_cnt_d;
    logic [SINCE_W:0]     since_plus1;
    logic                 frames_met;
    logic                 swap_go;
    logic                 miss_hit;

    // One extra bit so (counter+1) never wraps when the counter is saturated.
    assign since_plus1 = {1'b0, since_q} + (SINCE_W+1)'(1);
    assign frames_met  = since_plus1 >= (SINCE_W+1)'(MIN_FRAMES);
    assign swap_go     = (state_q == ST_WAIT_VB) && vblank_start && frames_met;
    assign miss_hit    = vblank_start && ((state_q == ST_CLEAR) || (state_q == ST_DRAW));

    always_comb begin
        since_d = since_q;
        if (swap_go) begin
            since_d = '0;
        end else if (vblank_start) begin
            since_d = since_sat_inc(since_q);
        end
    end

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_hit) begin
            miss_cnt_d = miss_sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            front_q       <= 1'b0;
            clear_start_q <= 1'b0;
            draw_start_q  <= 1'b0;
            swap_pulse_q  <= 1'b0;
            since_q       <= '0;
            miss_cnt_q    <= '0;
        end else begin
            clear_start_q <= 1'b0;
            draw_start_q  <= 1'b0;
            swap_pulse_q  <= 1'b0;
            since_q       <= since_d;
            miss_cnt_q    <= miss_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    state_q       <= JOB_ST;
                    clear_start_q <= CLEAR_EN;
                    draw_start_q  <= !CLEAR_EN;
                end
                ST_CLEAR: begin
                    if (clear_done) begin
                        state_q      <= ST_DRAW;
                        draw_start_q <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    // A vblank landing with draw_done is already counted as a miss.
                    if (draw_done) begin
                        state_q <= ST_WAIT_VB;
                    end
                end
                ST_WAIT_VB: begin
                    if (swap_go) begin
                        front_q       <= ~front_q;
                        swap_pulse_q  <= 1'b1;
                        state_q       <= JOB_ST;
                        clear_start_q <= CLEAR_EN;
                        draw_start_q  <= !CLEAR_EN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign front_sel   = front_q;
    assign back_sel    = ~front_q;
    assign clear_start = clear_start_q;
    assign draw_start  = draw_start_q;
    assign swap_pulse  = swap_pulse_q;
    assign state       = state_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: two instances (MIN_FRAMES=1/CLEAR_EN=1 and MIN_FRAMES=2/CLEAR_EN=0)
// share inputs; directed scenarios first, then random traffic against a frame-level model.
module tb_fb_swap_ctrl;

    logic        pix_clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblank_start = 1'b0;
    logic        draw_done = 1'b0;
    logic        clear_done = 1'b0;

    logic        a_front, a_back, a_cs, a_ds, a_sp;
    logic [1:0]  a_state;
    logic [15:0] a_miss;
    logic        b_front, b_back, b_cs, b_ds, b_sp;
    logic [1:0]  b_state;
    logic [15:0] b_miss;

    int checks = 0;
    int passes = 0;

    // Reference model: per instance, which job the back buffer is in, displayed buffer,
    // vblanks since the last flip, missed vblanks, and the one-cycle start/flip pulses.
    int m_job[2];    // 0 none yet, 1 clearing, 2 drawing, 3 frame ready
    bit m_front[2];
    int m_since[2];
    int m_miss[2];
    bit m_cs[2], m_ds[2], m_sp[2];
    int m_min[2] = '{1, 2};
    bit m_clr[2] = '{1'b1, 1'b0};

    always #5 pix_clk = ~pix_clk;

    fb_swap_ctrl #(.MIN_FRAMES(1), .CLEAR_EN(1'b1)) dut_a (
        .pix_clk(pix_clk), .rst(rst), .vblank_start(vblank_start), .draw_done(draw_done),
        .clear_done(clear_done), .front_sel(a_front), .back_sel(a_back), .clear_start(a_cs),
        .draw_start(a_ds), .swap_pulse(a_sp), .state(a_state), .miss_cnt(a_miss)
    );

    fb_swap_ctrl #(.MIN_FRAMES(2), .CLEAR_EN(1'b0)) dut_b (
        .pix_clk(pix_clk), .rst(rst), .vblank_start(vblank_start), .draw_done(draw_done),
        .clear_done(clear_done), .front_sel(b_front), .back_sel(b_back), .clear_start(b_cs),
        .draw_start(b_ds), .swap_pulse(b_sp), .state(b_state), .miss_cnt(b_miss)
    );

    task automatic tick();
        @(negedge pix_clk);
    endtask

    task automatic start_job(input int k);
        m_job[k] = m_clr[k] ? 1 : 2;
        m_cs[k]  = m_clr[k];
        m_ds[k]  = !m_clr[k];
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit flip;
            flip = 1'b0;
            if (rst) begin
                m_job[k] = 0; m_front[k] = 1'b0; m_since[k] = 0; m_miss[k] = 0;
                m_cs[k] = 1'b0; m_ds[k] = 1'b0; m_sp[k] = 1'b0;
            end else begin
                m_cs[k] = 1'b0; m_ds[k] = 1'b0; m_sp[k] = 1'b0;
                if (vblank_start && (m_job[k] == 1 || m_job[k] == 2) && m_miss[k] < 65535)
                    m_miss[k] = m_miss[k] + 1;
                if (m_job[k] == 3 && vblank_start && (m_since[k] + 1) >= m_min[k])
                    flip = 1'b1;
                if (flip) m_since[k] = 0;
                else if (vblank_start && m_since[k] < 255) m_since[k] = m_since[k] + 1;
                if (m_job[k] == 0) begin
                    start_job(k);
                end else if (m_job[k] == 1) begin
                    if (clear_done) begin m_job[k] = 2; m_ds[k] = 1'b1; end
                end else if (m_job[k] == 2) begin
                    if (draw_done) m_job[k] = 3;
                end else if (flip) begin
                    m_front[k] = ~m_front[k];
                    m_sp[k] = 1'b1;
                    start_job(k);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({a_state, a_front, a_back, a_cs, a_ds, a_sp, a_miss} !== {2'd0, 5'b01000, 16'd0})
            $display("FAIL reset_a got %b want %b", {a_state, a_front, a_back, a_cs, a_ds, a_sp, a_miss}, {2'd0, 5'b01000, 16'd0});
        else passes++;
        checks++;
        if ({b_state, b_front, b_back, b_cs, b_ds, b_sp, b_miss} !== {2'd0, 5'b01000, 16'd0})
            $display("FAIL reset_b got %b want %b", {b_state, b_front, b_back, b_cs, b_ds, b_sp, b_miss}, {2'd0, 5'b01000, 16'd0});
        else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if ({a_state, a_cs, a_ds} !== {2'd1, 1'b1, 1'b0})
            $display("FAIL first_clear_start got %b want %b", {a_state, a_cs, a_ds}, {2'd1, 1'b1, 1'b0});
        else passes++;
        checks++;
        if ({b_state, b_cs, b_ds} !== {2'd2, 1'b0, 1'b1})
            $display("FAIL first_draw_start_noclear got %b want %b", {b_state, b_cs, b_ds}, {2'd2, 1'b0, 1'b1});
        else passes++;
        tick();
        checks++;
        if ({a_state, a_cs} !== {2'd1, 1'b0})
            $display("FAIL clear_start_width got %b want %b", {a_state, a_cs}, {2'd1, 1'b0});
        else passes++;
    endtask

    task automatic test_clear_to_draw();
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        checks++;
        if ({a_state, a_ds, a_cs} !== {2'd2, 1'b1, 1'b0})
            $display("FAIL clear_done_to_draw got %b want %b", {a_state, a_ds, a_cs}, {2'd2, 1'b1, 1'b0});
        else passes++;
        checks++;
        if ({b_state, b_ds} !== {2'd2, 1'b0})
            $display("FAIL clear_done_ignored_in_draw got %b want %b", {b_state, b_ds}, {2'd2, 1'b0});
        else passes++;
        tick();
        checks++;
        if ({a_state, a_ds} !== {2'd2, 1'b0})
            $display("FAIL draw_start_width got %b want %b", {a_state, a_ds}, {2'd2, 1'b0});
        else passes++;
    endtask

    task automatic test_swap_min1();
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        checks++;
        if ({a_state, a_sp, a_front, b_state} !== {2'd3, 1'b0, 1'b0, 2'd3})
            $display("FAIL draw_done_to_wait got %b want %b", {a_state, a_sp, a_front, b_state}, {2'd3, 1'b0, 1'b0, 2'd3});
        else passes++;
        tick();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        checks++;
        if ({a_sp, a_front, a_back, a_cs, a_state} !== {4'b1101, 2'd1})
            $display("FAIL swap_min1 got %b want %b", {a_sp, a_front, a_back, a_cs, a_state}, {4'b1101, 2'd1});
        else passes++;
        checks++;
        if ({b_sp, b_front, b_state, b_miss} !== {2'b00, 2'd3, 16'd0})
            $display("FAIL min2_first_vblank_no_swap got %b want %b", {b_sp, b_front, b_state, b_miss}, {2'b00, 2'd3, 16'd0});
        else passes++;
        tick();
        checks++;
        if ({a_sp, a_cs, a_front} !== 3'b001)
            $display("FAIL swap_pulse_width got %b want %b", {a_sp, a_cs, a_front}, 3'b001);
        else passes++;
    endtask

    task automatic test_swap_min2();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        checks++;
        if ({b_sp, b_front, b_back, b_ds, b_state, b_miss} !== {4'b1101, 2'd2, 16'd0})
            $display("FAIL swap_min2_second_vblank got %b want %b", {b_sp, b_front, b_back, b_ds, b_state, b_miss}, {4'b1101, 2'd2, 16'd0});
        else passes++;
        checks++;
        if ({a_miss, a_front, a_sp} !== {16'd1, 1'b1, 1'b0})
            $display("FAIL miss_in_clear got %b want %b", {a_miss, a_front, a_sp}, {16'd1, 1'b1, 1'b0});
        else passes++;
        tick();
    endtask

    task automatic test_stall_miss();
        for (int i = 0; i < 3; i++) begin
            vblank_start = 1'b1; tick(); vblank_start = 1'b0;
            repeat (3) tick();
        end
        checks++;
        if ({b_miss, b_front, b_state, a_miss} !== {16'd3, 1'b1, 2'd2, 16'd4})
            $display("FAIL stall_three_misses got %h want %h", {b_miss, b_front, b_state, a_miss}, {16'd3, 1'b1, 2'd2, 16'd4});
        else passes++;
        vblank_start = 1'b1; draw_done = 1'b1; tick(); vblank_start = 1'b0; draw_done = 1'b0;
        checks++;
        if ({b_miss, b_front, b_sp, b_state} !== {16'd4, 2'b10, 2'd3})
            $display("FAIL coincident_done_vblank got %h want %h", {b_miss, b_front, b_sp, b_state}, {16'd4, 2'b10, 2'd3});
        else passes++;
        checks++;
        if ({a_state, a_miss} !== {2'd1, 16'd5})
            $display("FAIL draw_done_ignored_in_clear got %h want %h", {a_state, a_miss}, {2'd1, 16'd5});
        else passes++;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        checks++;
        if ({b_sp, b_front, b_state, b_miss} !== {2'b10, 2'd2, 16'd4})
            $display("FAIL swap_after_stall got %h want %h", {b_sp, b_front, b_state, b_miss}, {2'b10, 2'd2, 16'd4});
        else passes++;
        tick();
    endtask

    task automatic test_miss_sat();
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        force dut_a.miss_cnt_q = 16'hFFFE;
        #1;
        release dut_a.miss_cnt_q;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        checks++;
        if (a_miss !== 16'hFFFF)
            $display("FAIL miss_inc_to_max got %h want %h", a_miss, 16'hFFFF);
        else passes++;
        tick();
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        checks++;
        if ({a_miss, a_state, a_front} !== {16'hFFFF, 2'd2, 1'b1})
            $display("FAIL miss_saturate got %h want %h", {a_miss, a_state, a_front}, {16'hFFFF, 2'd2, 1'b1});
        else passes++;
        checks++;
        if (b_miss !== 16'd6)
            $display("FAIL miss_count_b got %0d want %0d", b_miss, 6);
        else passes++;
    endtask

    task automatic test_reset_midop();
        draw_done = 1'b1; tick(); draw_done = 1'b0;
        checks++;
        if ({a_state, a_front} !== {2'd3, 1'b1})
            $display("FAIL wait_vb_front1 got %b want %b", {a_state, a_front}, {2'd3, 1'b1});
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_state, a_front, a_back, a_cs, a_ds, a_sp, a_miss} !== {2'd0, 5'b01000, 16'd0})
            $display("FAIL async_reset_midop got %b want %b", {a_state, a_front, a_back, a_cs, a_ds, a_sp, a_miss}, {2'd0, 5'b01000, 16'd0});
        else passes++;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({a_state, a_cs, b_state, b_ds} !== {2'd1, 1'b1, 2'd2, 1'b1})
            $display("FAIL restart_after_reset got %b want %b", {a_state, a_cs, b_state, b_ds}, {2'd1, 1'b1, 2'd2, 1'b1});
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_cs, b_ds, a_state, b_state} !== {2'b00, 2'd0, 2'd0})
            $display("FAIL inflight_pulse_dropped got %b want %b", {a_cs, b_ds, a_state, b_state}, {2'b00, 2'd0, 2'd0});
        else passes++;
        tick();
        rst = 1'b0;
        tick();
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        checks++;
        if ({a_state, a_ds, a_front} !== {2'd2, 1'b1, 1'b0})
            $display("FAIL restart_clear_to_draw got %b want %b", {a_state, a_ds, a_front}, {2'd2, 1'b1, 1'b0});
        else passes++;
    endtask

    task automatic test_random();
        logic [22:0] exp_v;
        logic [22:0] obs_v;
        rst = 1'b1; vblank_start = 1'b0; draw_done = 1'b0; clear_done = 1'b0;
        model_step();
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst          = ($urandom_range(0, 299) == 0);
            vblank_start = ($urandom_range(0, 5) == 0);
            draw_done    = ($urandom_range(0, 3) == 0);
            clear_done   = ($urandom_range(0, 2) == 0);
            model_step();
            tick();
            for (int k = 0; k < 2; k++) begin
                exp_v = {m_job[k][1:0], m_front[k], ~m_front[k], m_cs[k], m_ds[k], m_sp[k], m_miss[k][15:0]};
                obs_v = (k == 0) ? {a_state, a_front, a_back, a_cs, a_ds, a_sp, a_miss}
                                 : {b_state, b_front, b_back, b_cs, b_ds, b_sp, b_miss};
                checks++;
                if (obs_v !== exp_v)
                    $display("FAIL random_dut%0d cycle %0d got %h want %h", k, cyc, obs_v, exp_v);
                else passes++;
            end
        end
        rst = 1'b0; vblank_start = 1'b0; draw_done = 1'b0; clear_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear_to_draw();
        test_swap_min1();
        test_swap_min2();
        test_stall_miss();
        test_miss_sat();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL have parameter MIN_FRAMES, default 1: minimum vblank_start pulses between two buffer swaps (1..255).
REQ-002 SHALL have parameter CLEAR_EN, default 1: 1 means a clear pass precedes every draw pass; 0 means clear is skipped.
REQ-003 SHALL have port pix_clk, input, 1: pixel clock, the only clock.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port vblank_start, input, 1: 1-cycle pulse at the end of the visible area, from the vertical counter.
REQ-006 SHALL have port draw_done, input, 1: 1-cycle pulse from the renderer; back buffer is complete.
REQ-007 SHALL have port clear_done, input, 1: 1-cycle pulse from the clear engine; back buffer is cleared.
REQ-008 SHALL have port front_sel, output, 1: buffer index scanned out to the display.
REQ-009 SHALL have port back_sel, output, 1: buffer index owned by renderer/clear; always ~front_sel.
REQ-010 SHALL have port clear_start, output, 1: 1-cycle pulse; start clearing back_sel.
REQ-011 SHALL have port draw_start, output, 1: 1-cycle pulse; start rendering into back_sel.
REQ-012 SHALL have port swap_pulse, output, 1: 1-cycle pulse in the cycle front_sel changes.
REQ-013 SHALL have port state, output, 2: current FSM state encoding.
REQ-014 SHALL have port miss_cnt, output, 16: saturating count of vblanks with no completed frame.

Function
REQ-015 SHALL implement FSM states IDLE=0, CLEAR=1, DRAW=2, WAIT_VB=3.
REQ-016 IDLE SHALL exit on the first clock after reset release: to CLEAR with clear_start=1 if CLEAR_EN, else to DRAW with draw_start=1.
REQ-017 clear_start and draw_start SHALL be registered and SHALL assert in the same cycle the state register enters CLEAR or DRAW, respectively.
REQ-018 CLEAR SHALL go to DRAW with draw_start=1 in the cycle after clear_done is sampled.
REQ-019 DRAW SHALL go to WAIT_VB in the cycle after draw_done is sampled.
REQ-020 Each sampled vblank_start SHALL increment an 8-bit since-swap counter, saturating at 255.
REQ-021 In WAIT_VB, a swap SHALL occur when vblank_start is sampled and (counter+1) >= MIN_FRAMES.
REQ-022 Swap SHALL take effect the cycle after the vblank_start sample: front_sel toggles, swap_pulse=1, counter clears to 0, and the FSM enters CLEAR (clear_start=1) or DRAW (draw_start=1) per CLEAR_EN.
REQ-023 miss_cnt SHALL increment, saturating at 16'hFFFF, on every vblank_start sampled in CLEAR or DRAW.
REQ-024 vblank_start in WAIT_VB that does not meet MIN_FRAMES SHALL NOT count as a miss.
REQ-025 If draw_done and vblank_start coincide in DRAW: no swap; the vblank counts as a miss; FSM goes to WAIT_VB.
REQ-026 draw_done outside DRAW and clear_done outside CLEAR SHALL be ignored with no state change.
REQ-027 front_sel SHALL change only at a swap, so a swap never lands inside the visible area.

Reset
REQ-028 While rst=1: state=IDLE, front_sel=0, back_sel=1, clear_start=0, draw_start=0, swap_pulse=0, miss_cnt=0, since-swap counter=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately; a pulse in flight SHALL be dropped, and the sequence restarts per REQ-016.

Structure
REQ-030 Package fb_pkg SHALL hold enum fb_state_t (2-bit) and localparam MISS_W=16.
REQ-031 The block SHALL be one flat module; no sub-module is needed; counters are inline.
REQ-032 All outputs SHALL be registered, except back_sel, which is ~front_sel.

Verification
REQ-033 Release reset, CLEAR_EN=1 -> clear_start at cycle 1; clear_done -> draw_start next cycle; state 1->2.
REQ-034 MIN_FRAMES=1: draw_done, then vblank_start at cycle t -> swap_pulse and front_sel 0->1 at t+1, clear_start at t+1.
REQ-035 MIN_FRAMES=2: draw_done quickly, then 2 vblanks -> swap only on the 2nd; miss_cnt stays 0.
REQ-036 Renderer stalls across 3 vblanks in DRAW -> miss_cnt=3, front_sel unchanged; coincident draw_done+vblank -> miss_cnt=4, no swap.
REQ-037 Force miss_cnt to 16'hFFFF and send another miss -> it stays at 16'hFFFF.
REQ-038 Assert rst in WAIT_VB with front_sel=1 -> all outputs take reset values immediately; restart sequence matches REQ-033.
